// File: rtl/dccm_arbiter_if.sv
// dccm_arbiter_if: LSU, DMA and DCCM signal bundle around the DCCM port arbiter.
interface dccm_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
   logic              lsu_rd_en_i, lsu_wr_en_i, lsu_stall_o;
   logic [ADDR_W-1:0] lsu_rd_addr_i, lsu_wr_addr_i;
   logic [DATA_W-1:0] lsu_wr_data_i, lsu_rd_data_o;
   logic              dma_req_i, dma_we_i, dma_gnt_o, dma_rvalid_o;
   logic [ADDR_W-1:0] dma_addr_i;
   logic [DATA_W-1:0] dma_wdata_i, dma_rdata_o;
   logic              dccm_wr_en_o, dccm_rd_en_o;
   logic [ADDR_W-1:0] dccm_wr_addr_o, dccm_rd_addr_o;
   logic [DATA_W-1:0] dccm_wr_data_o, dccm_rd_data_i;
   modport slave (
      input  lsu_rd_en_i, lsu_wr_en_i, lsu_rd_addr_i, lsu_wr_addr_i, lsu_wr_data_i,
      input  dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i, dccm_rd_data_i,
      output lsu_rd_data_o, lsu_stall_o, dma_gnt_o, dma_rvalid_o, dma_rdata_o,
      output dccm_wr_en_o, dccm_rd_en_o, dccm_wr_addr_o, dccm_rd_addr_o, dccm_wr_data_o
   );
   modport master (
      output lsu_rd_en_i, lsu_wr_en_i, lsu_rd_addr_i, lsu_wr_addr_i, lsu_wr_data_i,
      output dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i, dccm_rd_data_i,
      input  lsu_rd_data_o, lsu_stall_o, dma_gnt_o, dma_rvalid_o, dma_rdata_o,
      input  dccm_wr_en_o, dccm_rd_en_o, dccm_wr_addr_o, dccm_rd_addr_o, dccm_wr_data_o
   );
endinterface

// File: rtl/dccm_arbiter.sv
// dccm_arbiter: shares the DCCM port between the LSU (priority, zero latency) and a DMA
// requester, with a starvation counter that forces one DMA grant after STARVE_MAX blocked cycles.
module dccm_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 8
) (
   input logic clk,
   input logic rst_n,
   dccm_arbiter_if.slave bus
);
   localparam int CW = $clog2(STARVE_MAX + 1);
   typedef enum logic {NORMAL, FORCE} state_t;
   state_t  r_state;
   logic [CW-1:0] r_cnt;
   logic    w_lsu_req, w_gnt, w_lsu_rd, w_lsu_wr, w_dma_rd;
   assign w_lsu_req = bus.lsu_rd_en_i | bus.lsu_wr_en_i;
   assign w_gnt     = rst_n & bus.dma_req_i & ((r_state == FORCE) | ~w_lsu_req);
   // LSU owns the port whenever the DMA is not granted; everything is gated off in reset
   assign w_lsu_rd  = rst_n & ~w_gnt & bus.lsu_rd_en_i;
   assign w_lsu_wr  = rst_n & ~w_gnt & bus.lsu_wr_en_i;
   assign w_dma_rd  = w_gnt & ~bus.dma_we_i;
   assign bus.dma_gnt_o      = w_gnt;
   assign bus.lsu_stall_o    = rst_n & (r_state == FORCE) & w_lsu_req & bus.dma_req_i;
   assign bus.lsu_rd_data_o  = bus.dccm_rd_data_i;
   assign bus.dccm_wr_en_o   = w_gnt ? bus.dma_we_i : w_lsu_wr;
   assign bus.dccm_rd_en_o   = w_gnt ? ~bus.dma_we_i : w_lsu_rd;
   assign bus.dccm_wr_addr_o = w_gnt ? bus.dma_addr_i : w_lsu_wr ? bus.lsu_wr_addr_i : {ADDR_W{1'b0}};
   assign bus.dccm_rd_addr_o = w_gnt ? bus.dma_addr_i : w_lsu_rd ? bus.lsu_rd_addr_i : {ADDR_W{1'b0}};
   assign bus.dccm_wr_data_o = (w_gnt & bus.dma_we_i) ? bus.dma_wdata_i :
                               w_lsu_wr ? bus.lsu_wr_data_i : {DATA_W{1'b0}};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state          <= NORMAL;
         r_cnt            <= '0;
         bus.dma_rvalid_o <= 1'b0;
         bus.dma_rdata_o  <= {DATA_W{1'b0}};
      end else begin
         r_state          <= NORMAL;
         r_cnt            <= '0;
         bus.dma_rvalid_o <= w_dma_rd;
         if (w_dma_rd) bus.dma_rdata_o <= bus.dccm_rd_data_i;
         if (bus.dma_req_i & ~w_gnt) begin
            if (r_cnt == CW'(STARVE_MAX - 1)) r_state <= FORCE;
            else r_cnt <= r_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_dccm_arbiter.sv
// tb_dccm_arbiter: table-driven port checks plus directed multi-cycle sequences for dccm_arbiter.
module tb_dccm_arbiter;
   localparam int AW = 32, DW = 32, SM = 4;
   logic clk = 1'b0, rst_n = 1'b0;
   int   pass_n = 0, tot_n = 0;
   always #5 clk = ~clk;
   dccm_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
   dccm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always @(posedge clk) if (rst_n) assert (!(bus.lsu_rd_en_i && bus.lsu_wr_en_i)) else $error("illegal simultaneous LSU read and write");
   typedef struct {
      logic        lr, lw;
      logic [31:0] ra, wa, wd;
      logic        dq, dw;
      logic [31:0] da, dd, rd;
      logic        g, s, we, re;
      logic [31:0] ewa, era, ewd;
   } vec_t;
   vec_t v [8];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tot_n++;
      if (act === exp) pass_n++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask
   task automatic drive(input logic lr, lw, input logic [31:0] ra, wa, wd,
                        input logic dq, dw, input logic [31:0] da, dd, rd);
      bus.lsu_rd_en_i = lr; bus.lsu_wr_en_i = lw;
      bus.lsu_rd_addr_i = ra; bus.lsu_wr_addr_i = wa; bus.lsu_wr_data_i = wd;
      bus.dma_req_i = dq; bus.dma_we_i = dw; bus.dma_addr_i = da; bus.dma_wdata_i = dd;
      bus.dccm_rd_data_i = rd;
   endtask
   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   initial begin
      v[0] = '{1, 0, 'h100, 0, 0, 0, 0, 0, 0, 'hDEADBEEF, 0, 0, 0, 1, 0, 'h100, 0};
      v[1] = '{0, 1, 0, 'h200, 'hAABBCCDD, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'h200, 0, 'hAABBCCDD};
      v[2] = '{0, 0, 0, 0, 0, 1, 1, 'h40, 'h12345678, 0, 1, 0, 1, 0, 'h40, 'h40, 'h12345678};
      v[3] = '{0, 0, 0, 0, 0, 1, 0, 'h40, 0, 'h12345678, 1, 0, 0, 1, 'h40, 'h40, 0};
      v[4] = '{1, 0, 'h104, 0, 0, 1, 1, 'h80, 'h55, 'h11, 0, 0, 0, 1, 0, 'h104, 0};
      v[5] = '{0, 1, 0, 'h300, 'h77, 1, 0, 'h84, 0, 0, 0, 0, 1, 0, 'h300, 0, 'h77};
      v[6] = '{0, 0, 'h9, 'h9, 'h9, 0, 0, 0, 0, 'hCAFE, 0, 0, 0, 0, 0, 0, 0};
      v[7] = '{0, 0, 0, 0, 0, 0, 1, 'h44, 'h66, 0, 0, 0, 0, 0, 0, 0, 0};
      // reset: requests present but nothing may be granted or enabled
      drive(1, 0, 'h10, 0, 0, 1, 0, 'h20, 0, 0);
      #1;
      chk("rst_gnt", bus.dma_gnt_o, 0);
      chk("rst_stall", bus.lsu_stall_o, 0);
      chk("rst_rd_en", bus.dccm_rd_en_o, 0);
      chk("rst_wr_en", bus.dccm_wr_en_o, 0);
      chk("rst_rvalid", bus.dma_rvalid_o, 0);
      chk("rst_rdata", bus.dma_rdata_o, 0);
      @(negedge clk); idle(); rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         drive(v[i].lr, v[i].lw, v[i].ra, v[i].wa, v[i].wd, v[i].dq, v[i].dw, v[i].da, v[i].dd, v[i].rd);
         #1;
         chk($sformatf("v%0d_gnt", i), bus.dma_gnt_o, v[i].g);
         chk($sformatf("v%0d_stall", i), bus.lsu_stall_o, v[i].s);
         chk($sformatf("v%0d_wr_en", i), bus.dccm_wr_en_o, v[i].we);
         chk($sformatf("v%0d_rd_en", i), bus.dccm_rd_en_o, v[i].re);
         chk($sformatf("v%0d_wr_addr", i), bus.dccm_wr_addr_o, v[i].ewa);
         chk($sformatf("v%0d_rd_addr", i), bus.dccm_rd_addr_o, v[i].era);
         chk($sformatf("v%0d_wr_data", i), bus.dccm_wr_data_o, v[i].ewd);
         chk($sformatf("v%0d_lsu_rdata", i), bus.lsu_rd_data_o, v[i].rd);
         @(negedge clk); idle();
      end
      // DMA write then read at 0x40, read data one cycle after grant
      @(negedge clk); drive(0, 0, 0, 0, 0, 1, 1, 'h40, 'h12345678, 0); #1;
      chk("dw_gnt", bus.dma_gnt_o, 1);
      chk("dw_wr_en", bus.dccm_wr_en_o, 1);
      @(negedge clk); drive(0, 0, 0, 0, 0, 1, 0, 'h40, 0, 'h12345678); #1;
      chk("dr_gnt", bus.dma_gnt_o, 1);
      chk("dr_rvalid_early", bus.dma_rvalid_o, 0);
      @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 'h5A5A5A5A); #1;
      chk("dr_rvalid", bus.dma_rvalid_o, 1);
      chk("dr_rdata", bus.dma_rdata_o, 'h12345678);
      @(negedge clk); #1;
      chk("dr_rvalid_drop", bus.dma_rvalid_o, 0);
      chk("dr_rdata_hold", bus.dma_rdata_o, 'h12345678);
      // contention: LSU loads every cycle, DMA read waits SM cycles then is forced
      for (int c = 0; c < SM; c++) begin
         @(negedge clk); drive(1, 0, 'h500, 0, 0, 1, 0, 'h600, 0, 'hA0 + c); #1;
         chk($sformatf("ct%0d_gnt", c), bus.dma_gnt_o, 0);
         chk($sformatf("ct%0d_stall", c), bus.lsu_stall_o, 0);
         chk($sformatf("ct%0d_rd_addr", c), bus.dccm_rd_addr_o, 'h500);
      end
      @(negedge clk); drive(1, 0, 'h500, 0, 0, 1, 0, 'h600, 0, 'hF00D); #1;
      chk("ct4_gnt", bus.dma_gnt_o, 1);
      chk("ct4_stall", bus.lsu_stall_o, 1);
      chk("ct4_rd_addr", bus.dccm_rd_addr_o, 'h600);
      @(negedge clk); drive(1, 0, 'h500, 0, 0, 0, 0, 0, 0, 'hB5); #1;
      chk("ct5_gnt", bus.dma_gnt_o, 0);
      chk("ct5_stall", bus.lsu_stall_o, 0);
      chk("ct5_rd_addr", bus.dccm_rd_addr_o, 'h500);
      chk("ct5_cnt", dut.r_cnt, 0);
      chk("ct5_rvalid", bus.dma_rvalid_o, 1);
      chk("ct5_rdata", bus.dma_rdata_o, 'hF00D);
      // DMA request drops in the FORCE cycle
      for (int c = 0; c < SM; c++) begin
         @(negedge clk); drive(1, 0, 'h500, 0, 0, 1, 0, 'h600, 0, 0);
      end
      @(negedge clk); drive(1, 0, 'h500, 0, 0, 0, 0, 'h600, 0, 0); #1;
      chk("fd_gnt", bus.dma_gnt_o, 0);
      chk("fd_stall", bus.lsu_stall_o, 0);
      chk("fd_rd_addr", bus.dccm_rd_addr_o, 'h500);
      @(negedge clk); drive(1, 0, 'h500, 0, 0, 1, 0, 'h600, 0, 0); #1;
      chk("fd_next_gnt", bus.dma_gnt_o, 0);
      chk("fd_next_stall", bus.lsu_stall_o, 0);
      @(negedge clk); idle();
      // reset right after a DMA read grant
      @(negedge clk); drive(0, 0, 0, 0, 0, 1, 0, 'h88, 0, 'h99);
      @(posedge clk); #1;
      chk("rr_rvalid_pre", bus.dma_rvalid_o, 1);
      rst_n = 1'b0; drive(1, 0, 'h700, 0, 0, 1, 0, 'h88, 0, 0); #1;
      chk("rr_rvalid_now", bus.dma_rvalid_o, 0);
      chk("rr_rd_en", bus.dccm_rd_en_o, 0);
      @(negedge clk); @(negedge clk); #1;
      chk("rr_rvalid_hold", bus.dma_rvalid_o, 0);
      chk("rr_gnt", bus.dma_gnt_o, 0);
      idle(); rst_n = 1'b1;
      @(negedge clk); drive(1, 0, 'h700, 0, 0, 0, 0, 0, 0, 'hBEEF0001); #1;
      chk("rr_lsu_rd_en", bus.dccm_rd_en_o, 1);
      chk("rr_lsu_addr", bus.dccm_rd_addr_o, 'h700);
      chk("rr_lsu_stall", bus.lsu_stall_o, 0);
      chk("rr_lsu_data", bus.lsu_rd_data_o, 'hBEEF0001);
      // alternating LSU store / idle with continuous DMA read request
      for (int c = 0; c < 8; c++) begin
         @(negedge clk); drive(0, (c % 2) == 0, 0, 'h800 + c, c, 1, 0, 'h900, 0, c); #1;
         chk($sformatf("alt%0d_gnt", c), bus.dma_gnt_o, (c % 2) == 1);
         chk($sformatf("alt%0d_stall", c), bus.lsu_stall_o, 0);
         chk($sformatf("alt%0d_cnt_low", c), dut.r_cnt < SM - 1, 1);
      end
      @(negedge clk); idle();
      $display("%0d/%0d checks passed", pass_n, tot_n);
      $finish;
   end
endmodule

// File: doc/dccm_arbiter.md
# dccm_arbiter

Shares the single DCCM port between the LSU (pipeline MEM stage) and a secondary DMA/debug requester. The LSU has priority, and its DCCM signals pass through combinationally with zero added latency. The DMA port uses a req/gnt handshake. A starvation counter forces one DMA grant, and stalls the LSU for that cycle, after the DMA has been blocked for STARVE_MAX consecutive cycles. The block sits between `lsu` and the DCCM macro.

## Interface
- ADDR_W, default 32: address width for all ports.
- DATA_W, default 32: data width for all ports.
- STARVE_MAX, default 8: consecutive blocked DMA cycles before a forced grant. Must be ≥1.

- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- lsu_rd_en_i  in  1  LSU load request (from lsu dccm_rd_en_o)
- lsu_wr_en_i  in  1  LSU store request
- lsu_rd_addr_i  in  ADDR_W  LSU load address
- lsu_wr_addr_i  in  ADDR_W  LSU store address
- lsu_wr_data_i  in  DATA_W  LSU store data
- lsu_rd_data_o  out  DATA_W  load data to LSU, equal to dccm_rd_data_i (combinational)
- lsu_stall_o  out  1  LSU access not performed this cycle; LSU/pipeline holds
- dma_req_i  in  1  DMA access request
- dma_we_i  in  1  1 = write, 0 = read
- dma_addr_i  in  ADDR_W  DMA address
- dma_wdata_i  in  DATA_W  DMA write data
- dma_gnt_o  out  1  DMA access performed this cycle (combinational)
- dma_rvalid_o  out  1  registered DMA read data valid
- dma_rdata_o  out  DATA_W  registered DMA read data
- dccm_wr_en_o, dccm_rd_en_o  out  1  DCCM enables
- dccm_wr_addr_o, dccm_rd_addr_o  out  ADDR_W  DCCM addresses
- dccm_wr_data_o  out  DATA_W  DCCM write data
- dccm_rd_data_i  in  DATA_W  DCCM read data, valid in the same cycle as dccm_rd_en_o

## Operation
- Exactly one DCCM access per cycle.
- lsu_req = lsu_rd_en_i | lsu_wr_en_i. Simultaneous LSU read and write is illegal; the bench asserts on it.
- State NORMAL:
  - dma_gnt_o = dma_req_i & ~lsu_req.
  - lsu_stall_o = 0.
  - The LSU signals drive the DCCM when lsu_req is high.
- State FORCE:
  - dma_gnt_o = dma_req_i.
  - lsu_stall_o = lsu_req & dma_req_i.
  - The DMA drives the DCCM.
- DMA drive: dccm_wr_en_o = dma_we_i, dccm_rd_en_o = ~dma_we_i, and both addresses = dma_addr_i.
- Unused DCCM enables, addresses and write data are driven to 0.
- Transfer on the DMA port occurs in any cycle with dma_req_i & dma_gnt_o. dma_we_i, dma_addr_i and dma_wdata_i must be held stable until the grant.
- Starvation counter `cnt` (width clog2(STARVE_MAX+1)) updates at each clock edge:
  - If dma_req_i & ~dma_gnt_o and cnt == STARVE_MAX-1: cnt ← 0, state ← FORCE.
  - Else if dma_req_i & ~dma_gnt_o: cnt ← cnt+1.
  - Otherwise: cnt ← 0.
- FORCE lasts exactly one cycle, then returns to NORMAL whether or not a grant occurred. If dma_req_i drops in FORCE: no grant, no stall, return to NORMAL.
- DMA read pipeline:
  - On a granted read: dma_rvalid_o ← 1 and dma_rdata_o ← dccm_rd_data_i at the following edge.
  - Otherwise dma_rvalid_o ← 0, and dma_rdata_o holds its value.
- The LSU path adds no registers. lsu_rd_data_o always follows dccm_rd_data_i, so the LSU's own MEM register captures it as today.

## Timing
- Reset values: state NORMAL, cnt 0, dma_rvalid_o 0, dma_rdata_o 0.
- While rst_n is low, dma_gnt_o, lsu_stall_o and all DCCM enables are forced to 0.
- Reset asserted mid-operation drops any pending dma_rvalid_o and any FORCE in progress. No DCCM access occurs while in reset.
- LSU latency: 0 cycles added.
- DMA write latency: the access happens in the grant cycle.
- DMA read latency: data appears 1 cycle after the grant.
- Worst-case DMA wait: STARVE_MAX blocked cycles, then a grant in the next cycle.
- Back-to-back DMA requests with an idle LSU: one grant per cycle, and dma_rvalid_o may stay high continuously.
- Forced-grant stall: lsu_stall_o is high only in the FORCE cycle. The LSU re-presents the same access the next cycle and is served in NORMAL.

## Test plan
- LSU-only: load at 0x100 with DCCM data 0xDEADBEEF:
  - dccm_rd_en_o=1 and dccm_rd_addr_o=0x100 in the same cycle.
  - lsu_rd_data_o=0xDEADBEEF.
  - lsu_stall_o=0.
- DMA-only write then read at 0x40 with data 0x12345678:
  - Write: gnt in the request cycle, dccm_wr_en_o=1.
  - Read: gnt in its request cycle, then dma_rvalid_o=1 and dma_rdata_o=0x12345678 one cycle later.
- Contention, STARVE_MAX=4; LSU loads every cycle, DMA requests from cycle 0:
  - dma_gnt_o=0 in cycles 0–3.
  - Cycle 4: dma_gnt_o=1 and lsu_stall_o=1.
  - Cycle 5: LSU served, cnt=0.
- DMA request drops in the FORCE cycle: no gnt, lsu_stall_o=0, state returns to NORMAL next cycle.
- Reset asserted in the cycle after a DMA read grant: dma_rvalid_o=0 immediately and stays 0. After release, the first LSU access proceeds normally.
- Alternating LSU store / idle with a continuous DMA read request: DMA granted on every idle cycle, cnt never reaches STARVE_MAX-1, and no stall occurs.
